// File: rtl/meter_controller.sv
// ---------------------------------------------------------------------------
// meter_controller
//
// Sequencing controller for the parking-meter time adder. It captures
// coin-button presses, arbitrates between pending coins by fixed priority,
// and issues one add command at a time to the adder. It also generates the
// 1 s decrement strobe and drives the status LED from the adder's current
// total time.
//
// Parameters:
//   TICK_DIV   - clk cycles per 1 s tick
//   MAX_TIME   - saturation ceiling of total time in seconds
//   LOW_TIME   - total time below which the LED flashes
//   SETTLE_CYC - cycles waited after add_stb before the next grant
//
// Ports:
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high reset
//   coin       in   4   level buttons: bit0 +50, bit1 +150, bit2 +200, bit3 +500
//   total_time in  14   current meter time from the adder (seconds)
//   add_code   out  3   0 none, 1 +50, 2 +150, 3 +200, 4 +500 (valid with add_stb)
//   add_stb    out  1   one-cycle add command
//   dec_stb    out  1   one-cycle subtract-1-second request
//   coin_ack   out  4   one-cycle pulse per coin bit when its request is consumed
//   busy       out  1   high while issuing or settling
//   expired    out  1   high when total_time is zero
//   led        out  1   status LED
//
// Build option:
//   COIN_SYNC_EN - when defined, coin passes through a 2-flop synchronizer
//                  before edge capture (adds 2 cycles of latency).
// ---------------------------------------------------------------------------
module meter_controller #(
   parameter int unsigned TICK_DIV   = 100000000,
   parameter int unsigned MAX_TIME   = 9999,
   parameter int unsigned LOW_TIME   = 200,
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  coin,
   input  logic [13:0] total_time,
   output logic [2:0]  add_code,
   output logic        add_stb,
   output logic        dec_stb,
   output logic [3:0]  coin_ack,
   output logic        busy,
   output logic        expired,
   output logic        led
);

   localparam int unsigned TW = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
   localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   localparam logic [13:0]   MAX_T      = 14'(MAX_TIME);
   localparam logic [13:0]   LOW_T      = 14'(LOW_TIME);
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_SETTLE = 2'd2
   } state_e;

   // ------------------------------------------------------------------------
   // Coin input path (optional synchronizer)
   // ------------------------------------------------------------------------
   logic [3:0] coin_s;

`ifdef COIN_SYNC_EN
   logic [3:0] sync1_q, sync1_d;
   logic [3:0] sync2_q, sync2_d;

   always_comb begin
      sync1_d = coin;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign coin_s = sync2_q;
`else
   assign coin_s = coin;
`endif

   // ------------------------------------------------------------------------
   // State declarations
   // ------------------------------------------------------------------------
   state_e          state_q, state_d;
   logic [3:0]      coin_prev_q, coin_prev_d;
   logic [3:0]      pend_q, pend_d;
   logic [1:0]      win_q, win_d;
   logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
   logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
   logic            dec_pend_q, dec_pend_d;
   logic            blink_q, blink_d;

   logic [3:0]      coin_edge;
   logic [3:0]      pend_clr;
   logic [1:0]      grant_idx;
   logic            tick;
   logic            time_nonzero;
   logic            time_low;

   assign time_nonzero = (total_time != 14'd0);
   assign time_low     = (total_time < LOW_T);
   assign expired      = ~time_nonzero;

   // ------------------------------------------------------------------------
   // Edge capture and pending flags
   // ------------------------------------------------------------------------
   always_comb begin
      coin_prev_d = coin_s;
      coin_edge   = coin_s & ~coin_prev_q;
      // A new edge in the same cycle its bit is consumed must survive.
      pend_d      = (pend_q & ~pend_clr) | coin_edge;
   end

   // Fixed priority: bit3 > bit2 > bit1 > bit0
   always_comb begin
      grant_idx = 2'd0;
      if (pend_q[3]) begin
         grant_idx = 2'd3;
      end else if (pend_q[2]) begin
         grant_idx = 2'd2;
      end else if (pend_q[1]) begin
         grant_idx = 2'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Free-running 1 s tick divider
   // ------------------------------------------------------------------------
   always_comb begin
      tick = (tick_cnt_q == TICK_LAST);
      if (tick) begin
         tick_cnt_d = '0;
      end else begin
         tick_cnt_d = tick_cnt_q + TW'(1);
      end
   end

   // ------------------------------------------------------------------------
   // LED blink flop: held at 1 while time is not low, so it restarts at 1
   // when total_time first drops below LOW_TIME.
   // ------------------------------------------------------------------------
   always_comb begin
      if (!time_low) begin
         blink_d = 1'b1;
      end else if (tick) begin
         blink_d = ~blink_q;
      end else begin
         blink_d = blink_q;
      end
      led = time_low ? blink_q : 1'b1;
   end

   // ------------------------------------------------------------------------
   // Sequencing FSM: next state and outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      win_d        = win_q;
      settle_cnt_d = settle_cnt_q;
      dec_pend_d   = dec_pend_q;
      pend_clr     = '0;
      add_stb      = 1'b0;
      add_code     = 3'd0;
      dec_stb      = 1'b0;
      coin_ack     = '0;
      busy         = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Deferred or fresh tick is issued here; the zero check is
            // applied at issue time so a held decrement never underflows.
            dec_stb    = (tick | dec_pend_q) & time_nonzero;
            dec_pend_d = 1'b0;
            if (|pend_q) begin
               win_d   = grant_idx;
               state_d = S_ISSUE;
            end
         end

         S_ISSUE: begin
            busy       = 1'b1;
            dec_pend_d = dec_pend_q | tick;
            if (total_time < MAX_T) begin
               add_stb  = 1'b1;
               add_code = {1'b0, win_q} + 3'd1;
            end
            coin_ack     = 4'(4'b0001 << win_q);
            pend_clr     = 4'(4'b0001 << win_q);
            settle_cnt_d = '0;
            state_d      = (SETTLE_CYC == 0) ? S_IDLE : S_SETTLE;
         end

         S_SETTLE: begin
            busy       = 1'b1;
            dec_pend_d = dec_pend_q | tick;
            if (settle_cnt_q == SETTLE_LAST) begin
               settle_cnt_d = '0;
               state_d      = S_IDLE;
            end else begin
               settle_cnt_d = settle_cnt_q + SW'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         coin_prev_q  <= '0;
         pend_q       <= '0;
         win_q        <= '0;
         settle_cnt_q <= '0;
         tick_cnt_q   <= '0;
         dec_pend_q   <= 1'b0;
         blink_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         coin_prev_q  <= coin_prev_d;
         pend_q       <= pend_d;
         win_q        <= win_d;
         settle_cnt_q <= settle_cnt_d;
         tick_cnt_q   <= tick_cnt_d;
         dec_pend_q   <= dec_pend_d;
         blink_q      <= blink_d;
      end
   end

endmodule

// File: doc/meter_controller.md
Name: meter_controller

Overview:
- Sequencing controller for the parking-meter time adder.
- Captures coin-button presses and arbitrates simultaneous presses by fixed priority.
- Issues one add command at a time to the adder and generates the 1 s decrement strobe.
- Drives the status LED from the adder's current total time; sits between the debounced board buttons and the adder.

Parameters:
- TICK_DIV, 100000000, clk cycles per 1 s tick (bench uses 10).
- MAX_TIME, 9999, saturation ceiling of total time in seconds.
- LOW_TIME, 200, threshold below which the LED flashes.
- SETTLE_CYC, 2, cycles waited after add_stb before the next grant (adder latency + 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- coin  in  4  level button inputs: bit0 +50 s, bit1 +150 s, bit2 +200 s, bit3 +500 s.
- total_time  in  14  current meter time from the adder, in seconds.
- add_code  out  3  adder operation code: 0 none, 1 +50, 2 +150, 3 +200, 4 +500.
- add_stb  out  1  one-cycle add command; add_code is valid only while add_stb=1.
- dec_stb  out  1  one-cycle request to the adder to subtract 1 s.
- coin_ack  out  4  one-cycle pulse per coin bit when its request is consumed.
- busy  out  1  high in ISSUE and SETTLE.
- expired  out  1  high when total_time==0.
- led  out  1  status LED.

Behaviour:
- Reset: one clock, synchronous, active-high. All state, pending flags, the tick counter and the blink flop clear. Outputs after reset:
  - add_code=0, add_stb=0, dec_stb=0, coin_ack=0, busy=0, led=0.
  - expired follows total_time combinationally.
  - Reset mid-ISSUE or mid-SETTLE drops all pending requests, with no ack.
- Edge capture: a rising edge of coin[i] (registered previous value) sets pend[i]. Holding a button produces one request. A second edge while pend[i] is already set is merged.
- Arbiter: fixed priority, bit3 > bit2 > bit1 > bit0. It evaluates only in IDLE.
- FSM:
  - IDLE: if any pend bit is set, latch the winner index and go to ISSUE; otherwise stay.
  - ISSUE (1 cycle), on the pending coin:
    - If total_time < MAX_TIME: add_stb=1, add_code = winner+1.
    - Else: add_stb=0 (request dropped).
    - In both cases coin_ack[winner]=1, pend[winner] clears, and the FSM goes to SETTLE.
  - SETTLE: count SETTLE_CYC cycles, then return to IDLE.
  - Latency: button edge at cycle N gives edge detect at N+1 (registered), IDLE grant at N+1, ISSUE (add_stb) at N+2.
- Saturation: the adder clamps at MAX_TIME. The controller only suppresses adds when total_time is already at MAX_TIME.
- Tick counter:
  - Counts 0..TICK_DIV-1 freely; the wrap cycle is the tick.
  - On a tick with total_time != 0, dec_stb=1 for one cycle.
  - If a tick coincides with ISSUE or SETTLE, the decrement is held in dec_pend and issued in the first IDLE cycle. A decrement is never lost and is never issued in the same cycle as add_stb.
  - At most one dec_pend is held; a second tick while pending is merged.
  - dec_pend is re-checked against total_time != 0 when it is issued.
- LED:
  - total_time ≥ LOW_TIME: led=1.
  - 0 < total_time < LOW_TIME: led toggles every tick (0.5 Hz square wave).
  - total_time == 0: led toggles every tick and expired=1.
  - The blink flop restarts at 1 when total_time crosses from ≥ LOW_TIME to below it.
- Arithmetic: the tick counter width is clog2(TICK_DIV). All compares are unsigned 14-bit.

Optional Feature:
- Macro: COIN_SYNC_EN.
- Defined: coin passes through a 2-flop synchronizer before edge capture, adding 2 cycles of latency (ISSUE at N+4). Reset clears the synchronizer flops.
- Undefined: coin feeds edge capture directly, with timing as stated above.

Test Plan:
- Reset, total_time=0, coin=0, TICK_DIV=10 -> expired=1, add_stb never asserts, dec_stb never asserts, led toggles every 10 cycles.
- coin=0001 at cycle 20, held 30 cycles -> exactly one add_stb with add_code=1 at cycle 22, and coin_ack[0] at cycle 22.
- coin=1011 in the same cycle -> add_stb in three consecutive grants with add_code 4, then 2, then 1, each separated by SETTLE_CYC+1 cycles, with matching coin_ack bits.
- total_time=9999, coin bit3 pulse -> coin_ack[3]=1 and add_stb=0.
- Tick forced to coincide with ISSUE (total_time=300) -> dec_stb fires on the first IDLE cycle after SETTLE, never with add_stb.
- total_time=150, assert reset in SETTLE with pend[1] set -> all outputs 0 the next cycle, no later add_stb. Also total_time 250→150 -> led goes from steady 1 to toggling per tick.
